// File: rtl/seg_pkg.sv
// Shared types and segment constants for the seven-segment display controller.
// Codes are stored active-low, segment order bit6..0 = a,b,c,d,e,f,g.
package seg_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      CONV = 1'b1
   } state_t;

   localparam logic [6:0] SEG_0     = 7'h01;
   localparam logic [6:0] SEG_1     = 7'h4F;
   localparam logic [6:0] SEG_2     = 7'h12;
   localparam logic [6:0] SEG_3     = 7'h06;
   localparam logic [6:0] SEG_4     = 7'h4C;
   localparam logic [6:0] SEG_5     = 7'h24;
   localparam logic [6:0] SEG_6     = 7'h20;
   localparam logic [6:0] SEG_7     = 7'h0F;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h04;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Smallest digit count whose decimal range covers every BIN_W-bit value.
   function automatic int min_digits(input int bin_w);
      longint max_val;
      longint pow10;
      int     d;
      max_val = (longint'(1) << bin_w) - 1;
      d       = 1;
      pow10   = 10;
      while (pow10 <= max_val) begin
         d     = d + 1;
         pow10 = pow10 * 10;
      end
      return d;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD nibble to seven-segment decoder with blanking.
// Non-decimal nibbles decode to blank.
module seg7_decode
   import seg_pkg::*;
#(
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic [3:0] bcd,
   input  logic       blank,
   output logic [6:0] seg
);

   logic [6:0] code_low;

   always_comb begin
      case (bcd)
         4'd0:    code_low = SEG_0;
         4'd1:    code_low = SEG_1;
         4'd2:    code_low = SEG_2;
         4'd3:    code_low = SEG_3;
         4'd4:    code_low = SEG_4;
         4'd5:    code_low = SEG_5;
         4'd6:    code_low = SEG_6;
         4'd7:    code_low = SEG_7;
         4'd8:    code_low = SEG_8;
         4'd9:    code_low = SEG_9;
         default: code_low = SEG_BLANK;
      endcase
      if (blank) begin
         code_low = SEG_BLANK;
      end
   end

   assign seg = ACTIVE_LOW ? code_low : ~code_low;

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Binary-to-BCD display controller: sequential double-dabble conversion into a
// held display register, static per-digit segments and a scanned digit output.
module seven_seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int BIN_W      = 8,
   parameter int DIGITS     = 3,
   parameter int SCAN_DIV   = 1000,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  bin_valid,
   input  logic [BIN_W-1:0]      bin,
   output logic                  bin_ready,
   input  logic                  blank_lz,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic [7*DIGITS-1:0]   seg_static,
   output logic [DIGITS-1:0]     scan_an,
   output logic [6:0]            scan_seg
);

   localparam int WORK_W = 4 * DIGITS;
   localparam int CNT_W  = $clog2(BIN_W + 1);
   localparam int PRE_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   if (DIGITS < min_digits(BIN_W)) begin : g_bad_digits
      $error("DIGITS is too small to hold every BIN_W-bit value");
   end
   if (SCAN_DIV < 1) begin : g_bad_scan_div
      $error("SCAN_DIV must be at least 1");
   end

   state_t              state_reg;
   logic                ready_reg;
   logic [BIN_W-1:0]    shift_reg;
   logic [WORK_W-1:0]   work_reg;
   logic [WORK_W-1:0]   work_adj;
   logic [WORK_W-1:0]   work_next;
   logic [WORK_W-1:0]   bcd_reg;
   logic [CNT_W-1:0]    step_reg;
   logic [PRE_W-1:0]    pre_reg;
   logic [IDX_W-1:0]    idx_reg;
   logic [DIGITS-1:0]   lz_blank;
   logic [DIGITS-1:0]   an_onehot;
   logic                upper_zero;

   // One double-dabble step: add-3 correction, then shift the next input bit in.
   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign work_adj[4*gi +: 4] = (work_reg[4*gi +: 4] >= 4'd5) ?
                                   work_reg[4*gi +: 4] + 4'd3 : work_reg[4*gi +: 4];
   end
   assign work_next = {work_adj[WORK_W-2:0], shift_reg[BIN_W-1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         ready_reg <= 1'b1;
         shift_reg <= '0;
         work_reg  <= '0;
         step_reg  <= '0;
         bcd_reg   <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (bin_valid) begin
                  shift_reg <= bin;
                  work_reg  <= '0;
                  step_reg  <= CNT_W'(BIN_W);
                  state_reg <= CONV;
                  ready_reg <= 1'b0;
               end
            end
            CONV: begin
               work_reg  <= work_next;
               shift_reg <= shift_reg << 1;
               step_reg  <= step_reg - 1'b1;
               // Only the final step publishes, so the display never sees partial work.
               if (step_reg == CNT_W'(1)) begin
                  bcd_reg   <= work_next;
                  state_reg <= IDLE;
                  ready_reg <= 1'b1;
               end
            end
            default: begin
               state_reg <= IDLE;
               ready_reg <= 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_reg <= '0;
         idx_reg <= '0;
      end else if (pre_reg == PRE_W'(SCAN_DIV - 1)) begin
         pre_reg <= '0;
         idx_reg <= (idx_reg == IDX_W'(DIGITS - 1)) ? '0 : idx_reg + 1'b1;
      end else begin
         pre_reg <= pre_reg + 1'b1;
      end
   end

   // Digit k>0 blanks when it and every digit above it are zero.
   always_comb begin
      lz_blank   = '0;
      upper_zero = 1'b1;
      for (int k = DIGITS - 1; k >= 1; k--) begin
         upper_zero  = upper_zero & (bcd_reg[4*k +: 4] == 4'd0);
         lz_blank[k] = blank_lz & upper_zero;
      end
   end

   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      seg7_decode #(
         .ACTIVE_LOW (ACTIVE_LOW)
      ) u_dec (
         .bcd   (bcd_reg[4*gi +: 4]),
         .blank (lz_blank[gi]),
         .seg   (seg_static[7*gi +: 7])
      );
      assign an_onehot[gi] = (idx_reg == IDX_W'(gi));
   end

   always_comb begin
      scan_seg = '0;
      for (int k = 0; k < DIGITS; k++) begin
         if (idx_reg == IDX_W'(k)) begin
            scan_seg = seg_static[7*k +: 7];
         end
      end
   end

   assign scan_an   = ACTIVE_LOW ? ~an_onehot : an_onehot;
   assign bin_ready = ready_reg;
   assign bcd_out   = bcd_reg;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench: table vectors, random conversions against a decimal
// reference model, scan timing, back-to-back throughput, reset abort, wide config.
module tb_seven_seg_scan_ctrl;

   localparam int SD8  = 4;
   localparam int SD16 = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        blank_lz = 1'b0;

   logic        v8 = 1'b0;
   logic [7:0]  b8 = '0;
   logic        r8;
   logic [11:0] bcd8;
   logic [20:0] ss8;
   logic [2:0]  an8;
   logic [6:0]  sg8;

   logic        v16 = 1'b0;
   logic [15:0] b16 = '0;
   logic        r16;
   logic [19:0] bcd16;
   logic [34:0] ss16;
   logic [4:0]  an16;
   logic [6:0]  sg16;

   int     checks = 0;
   int     failures = 0;
   int     tb_cyc = 0;
   longint last8 = 0;
   longint last16 = 0;
   logic [6:0] codes [10] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C,
                              7'h24, 7'h20, 7'h0F, 7'h00, 7'h04};

   typedef struct {
      int         value;
      bit         lz;
      logic [11:0] bcd;
      logic [6:0] s2;
      logic [6:0] s1;
      logic [6:0] s0;
   } vec_t;
   vec_t vecs [8];

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) tb_cyc <= 0;
      else        tb_cyc <= tb_cyc + 1;
   end

   seven_seg_scan_ctrl #(
      .BIN_W(8), .DIGITS(3), .SCAN_DIV(SD8), .ACTIVE_LOW(1'b1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bin_valid(v8), .bin(b8), .bin_ready(r8),
      .blank_lz(blank_lz), .bcd_out(bcd8), .seg_static(ss8),
      .scan_an(an8), .scan_seg(sg8)
   );

   seven_seg_scan_ctrl #(
      .BIN_W(16), .DIGITS(5), .SCAN_DIV(SD16), .ACTIVE_LOW(1'b0)
   ) dut16 (
      .clk(clk), .rst_n(rst_n), .bin_valid(v16), .bin(b16), .bin_ready(r16),
      .blank_lz(blank_lz), .bcd_out(bcd16), .seg_static(ss16),
      .scan_an(an16), .scan_seg(sg16)
   );

   function automatic longint p10(input int k);
      longint r;
      r = 1;
      for (int i = 0; i < k; i++) r = r * 10;
      return r;
   endfunction

   function automatic logic [63:0] to_bcd(input longint v);
      logic [63:0] r;
      r = '0;
      for (int k = 0; k < 16; k++) r[4*k +: 4] = 4'((v / p10(k)) % 10);
      return r;
   endfunction

   // Displayed code for digit k of decimal value v.
   function automatic logic [6:0] seg_model(input longint v, input int k,
                                            input bit lz, input bit al);
      logic [6:0] c;
      int d;
      d = int'((v / p10(k)) % 10);
      if (k > 0 && lz && v < p10(k)) c = 7'h7F;
      else                           c = codes[d];
      return al ? c : ~c;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_static8(input longint v);
      for (int k = 0; k < 3; k++)
         check($sformatf("seg8_d%0d", k), 64'(ss8[7*k +: 7]), 64'(seg_model(v, k, blank_lz, 1'b1)));
   endtask

   task automatic check_static16(input longint v);
      for (int k = 0; k < 5; k++)
         check($sformatf("seg16_d%0d", k), 64'(ss16[7*k +: 7]), 64'(seg_model(v, k, blank_lz, 1'b0)));
   endtask

   task automatic check_scan8(input longint v);
      int idx;
      logic [2:0] exp_an;
      idx = (tb_cyc / SD8) % 3;
      exp_an = 3'b111 ^ (3'b001 << idx);
      check("scan_an8", 64'(an8), 64'(exp_an));
      check("scan_seg8", 64'(sg8), 64'(seg_model(v, idx, blank_lz, 1'b1)));
   endtask

   task automatic check_scan16(input longint v);
      int idx;
      logic [4:0] exp_an;
      idx = (tb_cyc / SD16) % 5;
      exp_an = 5'b00001 << idx;
      check("scan_an16", 64'(an16), 64'(exp_an));
      check("scan_seg16", 64'(sg16), 64'(seg_model(v, idx, blank_lz, 1'b0)));
   endtask

   // Called at a negedge with the DUT idle; returns at the negedge after completion.
   task automatic run_conv(input bit wide, input longint v);
      int lows;
      bit changed;
      logic [63:0] old_bcd;
      old_bcd = to_bcd(wide ? last16 : last8);
      check(wide ? "ready16_pre" : "ready8_pre", 64'(wide ? r16 : r8), 64'd1);
      if (wide) begin b16 = 16'(v); v16 = 1'b1; end
      else      begin b8 = 8'(v);   v8 = 1'b1; end
      @(posedge clk);
      @(negedge clk);
      v8 = 1'b0; v16 = 1'b0;
      b8 = 8'($urandom); b16 = 16'($urandom);
      lows = 0;
      changed = 1'b0;
      while (!(wide ? r16 : r8) && lows < 40) begin
         if ((wide ? 64'(bcd16) : 64'(bcd8)) !== old_bcd) changed = 1'b1;
         lows++;
         @(negedge clk);
      end
      check(wide ? "busy16_cycles" : "busy8_cycles", 64'(lows), wide ? 64'd16 : 64'd8);
      check(wide ? "no_partial16" : "no_partial8", 64'(changed), 64'd0);
      check(wide ? "bcd16" : "bcd8", wide ? 64'(bcd16) : 64'(bcd8), to_bcd(v));
      if (wide) last16 = v; else last8 = v;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      v8 = 1'b0; v16 = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      last8 = 0; last16 = 0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{255, 1'b0, 12'h255, 7'h12, 7'h24, 7'h24};
      vecs[1] = '{7,   1'b1, 12'h007, 7'h7F, 7'h7F, 7'h0F};
      vecs[2] = '{0,   1'b1, 12'h000, 7'h7F, 7'h7F, 7'h01};
      vecs[3] = '{0,   1'b0, 12'h000, 7'h01, 7'h01, 7'h01};
      vecs[4] = '{199, 1'b0, 12'h199, 7'h4F, 7'h04, 7'h04};
      vecs[5] = '{40,  1'b1, 12'h040, 7'h7F, 7'h4C, 7'h01};
      vecs[6] = '{100, 1'b1, 12'h100, 7'h4F, 7'h01, 7'h01};
      vecs[7] = '{9,   1'b1, 12'h009, 7'h7F, 7'h7F, 7'h04};

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_ready8", 64'(r8), 64'd1);
      check("rst_bcd8", 64'(bcd8), 64'd0);
      check("rst_an8", 64'(an8), 64'(3'b110));
      check("rst_an16", 64'(an16), 64'(5'b00001));
      check_static8(0);
      blank_lz = 1'b1;
      #1;
      check("rst_seg8_lz", 64'(ss8), 64'({7'h7F, 7'h7F, 7'h01}));
      check_static16(0);
      @(negedge clk);
      rst_n = 1'b1;

      // Table vectors
      for (int i = 0; i < 8; i++) begin
         blank_lz = vecs[i].lz;
         run_conv(1'b0, vecs[i].value);
         check($sformatf("tbl%0d_bcd", i), 64'(bcd8), 64'(vecs[i].bcd));
         check($sformatf("tbl%0d_d2", i), 64'(ss8[20:14]), 64'(vecs[i].s2));
         check($sformatf("tbl%0d_d1", i), 64'(ss8[13:7]), 64'(vecs[i].s1));
         check($sformatf("tbl%0d_d0", i), 64'(ss8[6:0]), 64'(vecs[i].s0));
         check_scan8(vecs[i].value);
      end

      // Randomized conversions against the decimal model
      for (int i = 0; i < 20; i++) begin
         longint v;
         v = longint'($urandom_range(0, 255));
         blank_lz = 1'($urandom);
         run_conv(1'b0, v);
         check_static8(v);
         check_scan8(v);
         blank_lz = ~blank_lz;
         #1;
         check_static8(v);
      end

      // Scan timing from reset on both instances
      blank_lz = 1'b0;
      do_reset();
      for (int i = 0; i < 30; i++) begin
         check_scan8(0);
         check_scan16(0);
         @(negedge clk);
      end

      // Back-to-back acceptances with bin stepping every cycle
      blank_lz = 1'($urandom);
      do_reset();
      for (int e = 0; e < 45; e++) begin
         longint shown;
         shown = (e < 9) ? 0 : 9 * ((e - 9) / 9);
         check($sformatf("tput_ready_e%0d", e), 64'(r8), 64'((e % 9) == 0));
         check($sformatf("tput_bcd_e%0d", e), 64'(bcd8), to_bcd(shown));
         check_static8(shown);
         check_scan8(shown);
         b8 = 8'(e);
         v8 = 1'b1;
         @(negedge clk);
      end
      v8 = 1'b0;
      last8 = 36;
      repeat (10) @(negedge clk);

      // Reset during a conversion aborts it
      b8 = 8'd200;
      v8 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      v8 = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_bcd", 64'(bcd8), 64'd0);
      check("abort_ready", 64'(r8), 64'd1);
      @(negedge clk);
      check("abort_bcd_hold", 64'(bcd8), 64'd0);
      rst_n = 1'b1;
      last8 = 0; last16 = 0;
      @(negedge clk);
      check("abort_bcd_after", 64'(bcd8), 64'd0);
      run_conv(1'b0, 199);
      check("after_abort_199", 64'(bcd8), 64'(12'h199));

      // Wide, active-high instance
      blank_lz = 1'b0;
      run_conv(1'b1, 65535);
      check("wide_65535", 64'(bcd16), 64'(20'h65535));
      check("wide_d4_inv", 64'(ss16[34:28]), 64'(7'h5F));
      check("wide_d0_inv", 64'(ss16[6:0]), 64'(7'h5B));
      check_static16(65535);
      for (int i = 0; i < 8; i++) begin
         longint v;
         v = longint'($urandom_range(0, 65535));
         blank_lz = 1'($urandom);
         run_conv(1'b1, v);
         check_static16(v);
      end
      for (int i = 0; i < 16; i++) begin
         check_scan16(last16);
         @(negedge clk);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seven_seg_scan_ctrl.md
# seven_seg_scan_ctrl

Parametrised sequential binary-to-decimal display controller for the processor's debug and status readout. It accepts a `BIN_W`-bit unsigned value through a valid/ready handshake and converts it with a one-bit-per-cycle double-dabble engine. The result is held in a `DIGITS`-digit BCD display register. It drives both per-digit static segment buses and a time-multiplexed, scanned single-digit output with optional leading-zero blanking.

## Interface
- `BIN_W`, 8: width of the binary input.
- `DIGITS`, 3: number of BCD digits. Elaboration fails unless `10**DIGITS > 2**BIN_W - 1`.
- `SCAN_DIV`, 1000: clocks per scanned digit. Must be ≥1.
- `ACTIVE_LOW`, 1: segment and anode polarity. 1 means a lit segment or enabled anode is driven 0.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `bin_valid` in 1: input value offered.
- `bin` in `BIN_W`: unsigned value.
- `bin_ready` out 1: block in IDLE and accepting.
- `blank_lz` in 1: when 1, blank leading zeros.
- `bcd_out` out `4*DIGITS`: display register; digit k is `[4k+3:4k]`.
- `seg_static` out `7*DIGITS`: digit k is on `[7k+6:7k]`.
- `scan_an` out `DIGITS`: one-hot anode select.
- `scan_seg` out 7: segments of the currently selected digit.

## Operation
- Segment order is bit6..0 = a,b,c,d,e,f,g.
- Active-low codes for 0–9 are 01,4F,12,06,4C,24,20,0F,00,04 (hex, 7-bit).
- Blank is 7F. When `ACTIVE_LOW=0`, every code is inverted.
- FSM states:
  - IDLE: `bin_ready=1`. When `bin_valid` is high at an edge, latch `bin` into the shift register, clear the work BCD register, set the step counter to `BIN_W`, and go to CONV.
  - CONV: `bin_ready=0`. Each edge performs one step: every work nibble ≥5 gets +3, then `{work,shift}` shifts left by 1 with the input MSB entering the work LSB. The counter decrements.
  - On the step where the counter reaches 0, the post-shift work value is written into `bcd_out` and the FSM returns to IDLE.
- `bin_valid` is ignored in CONV. Input is not queued, and `bin` may change freely after acceptance.
- Leading-zero blanking: digit k>0 is blank when `blank_lz=1` and all digits ≥k are 0. Digit 0 is never blanked, so value 0 shows "0".
- Blanking is combinational on `blank_lz` and `bcd_out`. It applies to both `seg_static` and `scan_seg`.
- Scan: the prescaler counts 0..`SCAN_DIV-1`. On wrap, the digit index advances and wraps from `DIGITS-1` to 0.
- `scan_an` enables the indexed digit. `scan_seg` equals that digit's `seg_static` slice.
- Scanning runs continuously and independently of the FSM.

## Timing
- Reset values:
  - FSM in IDLE, `bin_ready=1`, `bcd_out=0`.
  - Prescaler 0, digit index 0, so `scan_an` selects digit 0.
  - `seg_static` shows "0" on digit 0. Other digits show "0", or blank when `blank_lz=1`.
- Latency: acceptance at edge T0; `bcd_out` updates at edge T0+`BIN_W`; `bin_ready` is high again in the following cycle.
- Throughput: one conversion per `BIN_W+1` cycles with `bin_valid` held high.
- `bcd_out` never shows intermediate work values. It changes only at a completion edge or at reset.
- Reset asserted mid-CONV aborts the conversion immediately: `bcd_out` goes to 0 and the FSM to IDLE. No partial result is ever published.
- Digit k is selected during cycles [k·`SCAN_DIV`, (k+1)·`SCAN_DIV`) after reset, modulo `DIGITS`·`SCAN_DIV`.
- A `bcd_out` update mid-scan takes effect on the selected digit in the same cycle. There is no scan restart.
- Outputs `seg_static`, `scan_seg` and `scan_an` are combinational from registers and `blank_lz`. No output path exists from `bin` or `bin_valid` other than `bin_ready`.

## Structure
- Shared package `seg_pkg` holds:
  - the FSM state typedef (IDLE, CONV);
  - the 10 active-low segment code constants and the blank code;
  - a function computing the minimum `DIGITS` for a given `BIN_W`.
- Sub-module `seg7_decode`: purely combinational nibble-to-segment decoder with inputs `bcd[3:0]` and `blank` and parameter `ACTIVE_LOW`.
  - Instantiated `DIGITS` times.
  - Non-decimal nibbles decode to blank.
- The top level holds the FSM, double-dabble datapath, display register, prescaler and scan mux.

## Test plan
- `BIN_W=8`, `DIGITS=3`, `blank_lz=0`: accept 255 → after exactly 8 cycles `bcd_out=12'h255`; digits 2/1/0 show codes 12/24/24; `bin_ready` low for 8 cycles.
- Accept 7 with `blank_lz=1` → digits 2 and 1 show 7F, digit 0 shows 0F. Accept 0 → digit 0 shows 01, others 7F. Set `blank_lz=0` → all digits show 01.
- `SCAN_DIV=4`, active-low → `scan_an` goes 110, 101, 011, 110… with 4 cycles each from reset; `scan_seg` tracks the selected digit.
- `bin_valid` held high with `bin` stepping 0,1,2… → a new acceptance every 9 cycles; values offered during CONV are dropped; every `bcd_out` is valid BCD.
- Assert `rst_n` low at cycle 4 of converting 200 → `bcd_out` stays 0 and `bin_ready=1`; after release, 199 converts to 12'h199.
- `BIN_W=16`, `DIGITS=5`, `ACTIVE_LOW=0`: 65535 → `bcd_out=20'h65535` after 16 cycles; segment codes are the bitwise inverses.
